// File: rtl/qam_demap.sv
// qam_demap: slices I/Q samples into constellation indices and packs the
// resulting symbol codes LSB-first into 32-bit words.
//   Config macro: QAM_GRAY_EN - Gray-code each axis index before packing.
//   Parameter   : AMP_SHIFT   - log2 of one constellation unit in input LSBs.
//   Ports       : dclk, rstn (async, active low)
//                 inphase/quadrature (signed 16b), sym_valid, modtyp[2:0],
//                 flush, data_ack -> data[31:0], data_valid, nsym[5:0],
//                 ovf (sticky), moderr
module qam_demap #(
  parameter int unsigned AMP_SHIFT = 8
) (
  input  logic               dclk,
  input  logic               rstn,
  input  logic signed [15:0] inphase,
  input  logic signed [15:0] quadrature,
  input  logic               sym_valid,
  input  logic [2:0]         modtyp,
  input  logic               flush,
  input  logic               data_ack,
  output logic [31:0]        data,
  output logic               data_valid,
  output logic [5:0]         nsym,
  output logic               ovf,
  output logic               moderr
);

  localparam int unsigned DW = 32;
  localparam int unsigned NW = 6;
  localparam int unsigned MW = 3;
  localparam int unsigned CW = 8;
  localparam int unsigned KW = 4;
  localparam int unsigned SW = 18;

  // log2 of the per-axis level count
  function automatic logic [2:0] axis_bits(input logic [MW-1:0] m);
    case (m)
      3'd0, 3'd1: axis_bits = 3'd1;
      3'd2:       axis_bits = 3'd2;
      3'd3:       axis_bits = 3'd3;
      default:    axis_bits = 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] sym_bits(input logic [MW-1:0] m);
    if (m == 3'd0) sym_bits = 4'd1;
    else           sym_bits = {axis_bits(m), 1'b0};
  endfunction

  function automatic logic [NW-1:0] words_per(input logic [MW-1:0] m);
    case (m)
      3'd0:    words_per = 6'd32;
      3'd1:    words_per = 6'd16;
      3'd2:    words_per = 6'd8;
      3'd3:    words_per = 6'd5;
      default: words_per = 6'd4;
    endcase
  endfunction

  // Saturating slicer: floor(x / 2^(AMP_SHIFT+1)) + L/2, clamped to [0, L-1]
  function automatic logic [KW-1:0] axis_idx(input logic signed [15:0] x,
                                             input logic [2:0] lg);
    logic signed [15:0]   sh;
    logic signed [SW-1:0] s;
    logic signed [SW-1:0] half;
    logic signed [SW-1:0] lmax;
    logic [KW-1:0]        k;
    sh   = x >>> (AMP_SHIFT + 1);
    s    = {{(SW-16){sh[15]}}, sh};
    half = SW'(1) << (lg - 3'd1);
    lmax = (SW'(1) << lg) - SW'(1);
    s    = s + half;
    if (s < 0)         k = '0;
    else if (s > lmax) k = lmax[KW-1:0];
    else               k = s[KW-1:0];
`ifdef QAM_GRAY_EN
    k = k ^ (k >> 1);
`endif
    axis_idx = k;
  endfunction

  // Symbol code for the incoming sample
  logic [2:0]    lg;
  logic [KW-1:0] ki;
  logic [KW-1:0] kq;
  logic [CW-1:0] code;

  always_comb begin
    lg = axis_bits(modtyp);
    ki = axis_idx(inphase, lg);
    kq = axis_idx(quadrature, lg);
    if (modtyp == 3'd0) code = CW'(ki);
    else                code = (CW'(ki) << lg) | CW'(kq);
  end

  // Stage 1: capture code, mode and flush; unsupported modes are dropped here
  logic [CW-1:0] s1_code;
  logic [MW-1:0] s1_mode;
  logic          s1_vld;
  logic          s1_fl;

  always_ff @(posedge dclk or negedge rstn) begin
    if (!rstn) begin
      s1_code <= '0;
      s1_mode <= '0;
      s1_vld  <= 1'b0;
      s1_fl   <= 1'b0;
      moderr  <= 1'b0;
    end else if (sym_valid || flush) begin
      s1_code <= code;
      s1_mode <= modtyp;
      s1_vld  <= sym_valid && (modtyp <= 3'd4);
      s1_fl   <= flush;
      if (sym_valid) moderr <= (modtyp > 3'd4);
    end else begin
      s1_vld <= 1'b0;
      s1_fl  <= 1'b0;
    end
  end

  // Stage 2: accumulate and decide what (if anything) is emitted this edge
  logic [DW-1:0] acc, base_acc, nxt_acc, emit_w;
  logic [NW-1:0] cnt, base_cnt, nxt_cnt, emit_n;
  logic [MW-1:0] mode, nxt_mode;
  logic [5:0]    shamt;
  logic          fl_pend, pend_nxt, emit;

  always_comb begin
    base_acc = acc;
    base_cnt = cnt;
    nxt_acc  = acc;
    nxt_cnt  = cnt;
    nxt_mode = mode;
    emit     = 1'b0;
    emit_w   = '0;
    emit_n   = '0;
    pend_nxt = 1'b0;
    shamt    = '0;
    if (s1_vld) begin
      // mode switch closes the current partial word first
      if ((cnt != '0) && (s1_mode != mode)) begin
        emit     = 1'b1;
        emit_w   = acc;
        emit_n   = cnt;
        base_acc = '0;
        base_cnt = '0;
      end
      shamt    = 6'(base_cnt * 6'(sym_bits(s1_mode)));
      nxt_acc  = base_acc | (DW'(s1_code) << shamt);
      nxt_cnt  = base_cnt + 6'd1;
      nxt_mode = s1_mode;
      if (nxt_cnt == words_per(s1_mode)) begin
        emit    = 1'b1;
        emit_w  = nxt_acc;
        emit_n  = nxt_cnt;
        nxt_acc = '0;
        nxt_cnt = '0;
      end
    end
    // a flush colliding with a mode-switch emission is deferred one edge
    if ((s1_fl || fl_pend) && (nxt_cnt != '0)) begin
      if (emit) begin
        pend_nxt = 1'b1;
      end else begin
        emit    = 1'b1;
        emit_w  = nxt_acc;
        emit_n  = nxt_cnt;
        nxt_acc = '0;
        nxt_cnt = '0;
      end
    end
  end

  always_ff @(posedge dclk or negedge rstn) begin
    if (!rstn) begin
      acc        <= '0;
      cnt        <= '0;
      mode       <= '0;
      fl_pend    <= 1'b0;
      data       <= '0;
      nsym       <= '0;
      data_valid <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      acc     <= nxt_acc;
      cnt     <= nxt_cnt;
      mode    <= nxt_mode;
      fl_pend <= pend_nxt;
      if (emit) begin
        if (!data_valid || data_ack) begin
          data       <= emit_w;
          nsym       <= emit_n;
          data_valid <= 1'b1;
        end else begin
          ovf <= 1'b1;
        end
      end else if (data_ack) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_qam_demap.sv
// tb_qam_demap: directed stimulus for qam_demap, checked every cycle against
// a queue-based behavioural model plus hand-computed literal expectations.
module tb_qam_demap;

  localparam int unsigned AMP_SHIFT = 8;

  logic               dclk = 1'b0;
  logic               rstn = 1'b1;
  logic signed [15:0] inphase = '0;
  logic signed [15:0] quadrature = '0;
  logic               sym_valid = 1'b0;
  logic [2:0]         modtyp = '0;
  logic               flush = 1'b0;
  logic               data_ack = 1'b0;
  logic [31:0]        data;
  logic               data_valid;
  logic [5:0]         nsym;
  logic               ovf;
  logic               moderr;

  int checks = 0;
  int errors = 0;

  qam_demap #(.AMP_SHIFT(AMP_SHIFT)) dut (
    .dclk(dclk), .rstn(rstn), .inphase(inphase), .quadrature(quadrature),
    .sym_valid(sym_valid), .modtyp(modtyp), .flush(flush), .data_ack(data_ack),
    .data(data), .data_valid(data_valid), .nsym(nsym), .ovf(ovf), .moderr(moderr)
  );

  always #5 dclk = ~dclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int levels_of(input int m);
    case (m)
      0, 1:    return 2;
      2:       return 4;
      3:       return 8;
      default: return 16;
    endcase
  endfunction

  function automatic int bits_of(input int m);
    return (m == 0) ? 1 : 2 * $clog2(levels_of(m));
  endfunction

  function automatic int spw_of(input int m);
    return 32 / bits_of(m);
  endfunction

  function automatic int axis(input int x, input int lv);
    int unit, q, k;
    unit = 1 << (AMP_SHIFT + 1);
    if (x >= 0) q = x / unit;
    else        q = -((-x + unit - 1) / unit);
    k = q + lv / 2;
    if (k < 0) k = 0;
    if (k > lv - 1) k = lv - 1;
`ifdef QAM_GRAY_EN
    k = k ^ (k >> 1);
`endif
    return k;
  endfunction

  function automatic int sym_code(input int m, input int i, input int q);
    int lv;
    lv = levels_of(m);
    if (m == 0) return axis(i, 2);
    return axis(i, lv) * lv + axis(q, lv);
  endfunction

  function automatic logic [31:0] pack(input int m, input int syms[$]);
    logic [63:0] w;
    w = '0;
    foreach (syms[i]) w = w + (64'(syms[i]) << (i * bits_of(m)));
    return w[31:0];
  endfunction

  int          mq[$];
  int          wmode = 0;
  bit          pendfl = 0, nextpend;
  bit          d_v = 0, d_f = 0;
  int          d_code = 0, d_mode = 0;
  bit          emitted;
  logic [31:0] ew;
  int          en;
  logic [31:0] e_data = '0;
  int          e_nsym = 0;
  bit          e_dv = 0, e_ovf = 0, e_merr = 0;

  always @(posedge dclk or negedge rstn) begin
    if (!rstn) begin
      mq.delete();
      wmode = 0; pendfl = 0; d_v = 0; d_f = 0; d_code = 0; d_mode = 0;
      e_data = '0; e_nsym = 0; e_dv = 0; e_ovf = 0; e_merr = 0;
    end else begin
      emitted = 0; ew = '0; en = 0; nextpend = 0;
      if (d_v) begin
        if (mq.size() > 0 && d_mode != wmode) begin
          emitted = 1; ew = pack(wmode, mq); en = mq.size(); mq.delete();
        end
        wmode = d_mode;
        mq.push_back(d_code);
        if (mq.size() == spw_of(wmode)) begin
          emitted = 1; ew = pack(wmode, mq); en = mq.size(); mq.delete();
        end
      end
      if ((d_f || pendfl) && mq.size() > 0) begin
        if (emitted) nextpend = 1;
        else begin
          emitted = 1; ew = pack(wmode, mq); en = mq.size(); mq.delete();
        end
      end
      pendfl = nextpend;
      if (emitted) begin
        if (!e_dv || data_ack) begin e_data = ew; e_nsym = en; e_dv = 1; end
        else e_ovf = 1;
      end else if (data_ack) e_dv = 0;
      if (sym_valid) e_merr = (modtyp > 3'd4);
      if (sym_valid || flush) begin
        d_v = sym_valid && (modtyp <= 3'd4);
        d_f = flush;
        d_mode = int'(modtyp);
        d_code = (modtyp <= 3'd4) ? sym_code(int'(modtyp), int'(inphase), int'(quadrature)) : 0;
      end else begin
        d_v = 0; d_f = 0;
      end
    end
  end

  // every-cycle comparison against the model
  always @(negedge dclk) begin
    if (rstn) begin
      chk("model_data", data, e_data);
      chk("model_nsym", 32'(nsym), 32'(e_nsym));
      chk("model_valid", 32'(data_valid), 32'(e_dv));
      chk("model_ovf", 32'(ovf), 32'(e_ovf));
      chk("model_moderr", 32'(moderr), 32'(e_merr));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input int i, input int q, input int m, input bit v, input bit f, input bit a);
    @(negedge dclk);
    inphase = 16'(i); quadrature = 16'(q); modtyp = 3'(m);
    sym_valid = v; flush = f; data_ack = a;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic ack_word(input string name);
    drive(0, 0, 0, 0, 0, 1);
    idle(1);
    chk({name, "_acked"}, 32'(data_valid), 32'd0);
  endtask

  initial begin
    #1 rstn = 1'b0;
    repeat (3) @(negedge dclk);
    chk("rst_data", data, 32'd0);
    chk("rst_valid", 32'(data_valid), 32'd0);
    chk("rst_nsym", 32'(nsym), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rstn = 1'b1;

    // 4-QAM full word
    repeat (16) drive(256, -256, 1, 1, 0, 0);
    idle(3);
    chk("qpsk_data", data, 32'hAAAAAAAA);
    chk("qpsk_nsym", 32'(nsym), 32'd16);
    chk("qpsk_valid", 32'(data_valid), 32'd1);
    ack_word("qpsk");

    // 16-QAM full word
    repeat (8) drive(768, -768, 2, 1, 0, 0);
    idle(3);
`ifdef QAM_GRAY_EN
    chk("qam16_data", data, 32'h88888888);
`else
    chk("qam16_data", data, 32'hCCCCCCCC);
`endif
    chk("qam16_nsym", 32'(nsym), 32'd8);
    ack_word("qam16");

    // BPSK with saturating inputs; Q is ignored
    for (int n = 0; n < 32; n++)
      drive((n % 2 == 0) ? 32767 : -32768, 12345, 0, 1, 0, 0);
    idle(3);
    chk("bpsk_data", data, 32'h55555555);
    chk("bpsk_nsym", 32'(nsym), 32'd32);
    ack_word("bpsk");

    // 64-QAM: 5 symbols, top two bits unused
    repeat (5) drive(3584, 3584, 3, 1, 0, 0);
    idle(3);
`ifdef QAM_GRAY_EN
    chk("qam64_data", data, 32'h24924924);
`else
    chk("qam64_data", data, 32'h3FFFFFFF);
`endif
    chk("qam64_nsym", 32'(nsym), 32'd5);
    ack_word("qam64");

    // 256-QAM partial word closed by a separate flush
    repeat (3) drive(3840, 3840, 4, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 0);
    idle(3);
`ifdef QAM_GRAY_EN
    chk("qam256_flush_data", data, 32'h00888888);
`else
    chk("qam256_flush_data", data, 32'h00FFFFFF);
`endif
    chk("qam256_flush_nsym", 32'(nsym), 32'd3);
    ack_word("qam256_flush");

    // flush on the same edge as the last symbol includes it
    drive(3840, 3840, 4, 1, 0, 0);
    drive(3840, 3840, 4, 1, 1, 0);
    idle(3);
    chk("flush_same_edge_nsym", 32'(nsym), 32'd2);
    ack_word("flush_same_edge");

    // flush with nothing accumulated emits nothing
    drive(0, 0, 0, 0, 1, 0);
    idle(3);
    chk("flush_empty_valid", 32'(data_valid), 32'd0);

    // mode change forces the partial word out
    repeat (3) drive(768, -768, 2, 1, 0, 0);
    drive(256, -256, 1, 1, 0, 0);
    idle(3);
`ifdef QAM_GRAY_EN
    chk("modechg_data", data, 32'h00000888);
`else
    chk("modechg_data", data, 32'h00000CCC);
`endif
    chk("modechg_nsym", 32'(nsym), 32'd3);
    ack_word("modechg");
    drive(0, 0, 0, 0, 1, 0);
    idle(3);
    chk("modechg_tail_data", data, 32'h00000002);
    chk("modechg_tail_nsym", 32'(nsym), 32'd1);
    ack_word("modechg_tail");

    // mode change and flush on the same edge, consumer always ready
    drive(256, -256, 1, 1, 0, 1);
    drive(256, -256, 1, 1, 0, 1);
    drive(768, -768, 2, 1, 1, 1);
    repeat (4) drive(0, 0, 0, 0, 0, 1);
    idle(2);

    // new word completes on the same edge as the ack: replaces, stays valid
    repeat (16) drive(256, -256, 1, 1, 0, 0);
    idle(3);
    repeat (16) drive(-256, 256, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 1);
    idle(2);
    chk("ack_same_edge_data", data, 32'h55555555);
    chk("ack_same_edge_valid", 32'(data_valid), 32'd1);
    chk("ack_same_edge_ovf", 32'(ovf), 32'd0);
    ack_word("ack_same_edge");

    // overflow: second word discarded
    repeat (16) drive(256, -256, 1, 1, 0, 0);
    repeat (16) drive(-256, 256, 1, 1, 0, 0);
    idle(3);
    chk("ovf_flag", 32'(ovf), 32'd1);
    chk("ovf_data_kept", data, 32'hAAAAAAAA);
    ack_word("ovf");
    chk("ovf_sticky", 32'(ovf), 32'd1);

    // unsupported mode dropped, then cleared by a good symbol
    drive(256, -256, 7, 1, 0, 0);
    idle(2);
    chk("moderr_set", 32'(moderr), 32'd1);
    drive(256, -256, 1, 1, 0, 0);
    idle(2);
    chk("moderr_clr", 32'(moderr), 32'd0);

    // reset mid-word discards the partial word and clears everything
    repeat (3) drive(-256, 256, 1, 1, 0, 0);
    idle(1);
    @(negedge dclk);
    #2 rstn = 1'b0;
    #1;
    chk("midrst_data", data, 32'd0);
    chk("midrst_valid", 32'(data_valid), 32'd0);
    chk("midrst_nsym", 32'(nsym), 32'd0);
    chk("midrst_ovf", 32'(ovf), 32'd0);
    chk("midrst_moderr", 32'(moderr), 32'd0);
    @(negedge dclk);
    rstn = 1'b1;
    repeat (16) drive(256, -256, 1, 1, 0, 0);
    idle(3);
    chk("postrst_data", data, 32'hAAAAAAAA);
    chk("postrst_nsym", 32'(nsym), 32'd16);
    ack_word("postrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/qam_demap.md
QAM_DEMAP -- requirements
Module: qam_demap

Interface
REQ-001 AMP_SHIFT, default 8, log2 of one constellation unit in input LSBs; nominal levels are odd multiples of 2^AMP_SHIFT.
REQ-002 dclk  input  1  clock; all state SHALL update on the rising edge.
REQ-003 rstn  input  1  asynchronous active-low reset.
REQ-004 inphase  input  16  signed two's-complement I sample.
REQ-005 quadrature  input  16  signed two's-complement Q sample.
REQ-006 sym_valid  input  1  I/Q sample valid this cycle.
REQ-007 modtyp  input  3  constellation: 0=2, 1=4, 2=16, 3=64, 4=256; 5-7 unsupported.
REQ-008 flush  input  1  emit the partial word.
REQ-009 data_ack  input  1  consumer takes data.
REQ-010 data  output  32  packed demapped bits.
REQ-011 data_valid  output  1  data holds an unconsumed word.
REQ-012 nsym  output  6  number of symbols packed in data.
REQ-013 ovf  output  1  sticky overflow flag.
REQ-014 moderr  output  1  last sampled symbol carried an unsupported modtyp.

Function
REQ-015 Per-axis levels L, bits per symbol B and symbols per word S SHALL be: modtyp 0: L=2 (I only), B=1, S=32; 1: L=2, B=2, S=16; 2: L=4, B=4, S=8; 3: L=8, B=6, S=5; 4: L=16, B=8, S=4.
REQ-016 Axis index SHALL be k = clamp((x >>> (AMP_SHIFT+1)) + L/2, 0, L-1), using an arithmetic shift and saturating at both ends.
REQ-017 Symbol code SHALL be {kI, kQ}, with kI in the upper B/2 bits; for modtyp 0 the code SHALL be kI and quadrature SHALL be ignored.
REQ-018 Stage 1 SHALL register the code, the sampled modtyp and flush on every edge where sym_valid or flush is high.
REQ-019 Stage 2 SHALL place the n-th symbol of a word at data bits [n*B+B-1 : n*B], LSB first; unused upper bits (bits 31:30 for modtyp 3) SHALL be 0.
REQ-020 A word completing at n==S SHALL load data, set nsym=S and assert data_valid on the edge after the edge that sampled its last symbol.
REQ-021 data_valid SHALL hold until data_ack is sampled high; data and nsym SHALL stay stable while data_valid is high.
REQ-022 A word completing while data_valid=1 without data_ack on the same edge SHALL be discarded and ovf set; if data_ack is high on that edge, the new word SHALL load and data_valid SHALL stay 1.
REQ-023 Flush SHALL travel with stage 1, so a symbol sampled on the same edge as flush is included; flush with an empty accumulator SHALL emit nothing.
REQ-024 Flush SHALL emit a partial word zero-padded above the packed bits, with nsym set to the symbol count and the same overflow rules.
REQ-025 A symbol whose sampled modtyp differs from the current word's mode SHALL force emission of the partial word and start a new word with that symbol on the same edge.
REQ-026 A symbol with modtyp 5-7 SHALL be dropped and SHALL set moderr; the next supported symbol SHALL clear moderr.

Reset
REQ-027 rstn low SHALL asynchronously clear data, data_valid, nsym, ovf, moderr, the accumulator, the stage-1 contents and any pending flush.
REQ-028 Reset mid-word SHALL discard the partial word; ovf SHALL be cleared only by reset.

Configuration
REQ-029 With QAM_GRAY_EN defined, each axis index SHALL be Gray coded (k ^ (k>>1)) before packing; without QAM_GRAY_EN, natural binary k SHALL be packed.

Verification
REQ-030 modtyp=1, 16 symbols I=+256, Q=-256 -> data=0xAAAAAAAA, nsym=16, with or without macro.
REQ-031 modtyp=2, 8 symbols I=+768, Q=-768 -> data=0xCCCCCCCC; with QAM_GRAY_EN, 0x88888888.
REQ-032 modtyp=0, 32 symbols alternating I=+32767 then I=-32768 -> data=0x55555555 (saturation).
REQ-033 modtyp=4, 3 symbols I=Q=+3840, then flush -> data=0x00FFFFFF, nsym=3; with QAM_GRAY_EN, 0x00888888.
REQ-034 Two full modtyp=1 words without data_ack -> ovf=1, data still the first word; then data_ack -> data_valid=0.
REQ-035 modtyp=7 symbol -> dropped, moderr=1; next modtyp=1 symbol -> moderr=0; rstn pulse mid-word -> all outputs 0.
